// File: rtl/seg7_pkg.sv
// Shared constants and types for the ALU front-panel seven-segment display.
// Contents: the hex glyph table, the dash and blank glyphs, the anode pattern
// for each digit, the scan-state enum, and a 4-bit absolute-value helper.
// Glyphs are active-low {g,f,e,d,c,b,a}, so a 0 bit lights that segment.
package seg7_pkg;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [7:0] AN_OP   = 8'h7F;
    localparam logic [7:0] AN_SIGN = 8'hFD;
    localparam logic [7:0] AN_MAG  = 8'hFE;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        ST_OP   = 2'd0,
        ST_SIGN = 2'd1,
        ST_MAG  = 2'd2
    } scan_state_t;

    // Two's-complement magnitude, modulo 16. An input of 4'b1000 returns 8.
    function automatic logic [3:0] abs4(input logic [3:0] v);
        return v[3] ? (~v + 4'd1) : v;
    endfunction

endpackage

// File: rtl/seg7_alu_display_if.sv
// Groups the display block's data signals into one bus.
//   op      ALU opcode to show on digit 7
//   result  ALU result to show on digits 1 and 0
//   display segment cathodes {g,f,e,d,c,b,a}, active-low
//   anode   digit enables, active-low and one-hot-low
// Modport master is the side that drives op/result; modport slave is the
// display block.
interface seg7_alu_display_if;
    logic [3:0] op;
    logic [3:0] result;
    logic [6:0] display;
    logic [7:0] anode;

    modport master (output op, output result, input display, input anode);
    modport slave  (input op, input result, output display, output anode);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Purely combinational decoder from a 4-bit number to an active-low hex glyph.
//   num  in   4-bit value to show
//   seg  out  cathodes {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] num,
    output logic [6:0] seg
);

    // Every 4-bit index is inside the table, so no fallback value is needed.
    assign seg = HEX_GLYPH[num];

endmodule

// File: rtl/seg7_alu_display.sv
// Front-panel display for the ALU. Three digits are time-multiplexed: digit 7
// shows the opcode as a hex glyph, digit 1 shows the sign of the result, and
// digit 0 shows its magnitude. With SIGNED_RESULT=0, digit 1 stays blank and
// digit 0 shows the raw result in hex.
//   clock  in     system clock, rising edge
//   rst    in     synchronous reset, active-high
//   bus    slave  op/result in; registered display/anode out
// Parameters:
//   SCAN_DIV       clocks each digit is held (1..2^20)
//   SIGNED_RESULT  1 = sign and magnitude, 0 = raw hex
//
// state   | meaning
// ST_OP   | digit 7 lit, showing the opcode glyph
// ST_SIGN | digit 1 lit, showing a dash for a negative result, else blank
// ST_MAG  | digit 0 lit, showing |result| (or the raw result)
module seg7_alu_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV      = 1,
    parameter bit SIGNED_RESULT = 1'b1
) (
    input  logic                clock,
    input  logic                rst,
    seg7_alu_display_if.slave   bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    scan_state_t   state;
    logic [PW-1:0] presc;
    logic          wrap;
    logic [3:0]    mag_num;
    logic [6:0]    op_glyph;
    logic [6:0]    mag_glyph;
    logic [6:0]    sign_glyph;

    assign wrap       = (presc == PRESC_LAST);
    assign mag_num    = SIGNED_RESULT ? abs4(bus.result) : bus.result;
    assign sign_glyph = (SIGNED_RESULT && bus.result[3]) ? GLYPH_DASH : GLYPH_BLANK;

    seg7_hex_decoder u_op_dec  (.num(bus.op),  .seg(op_glyph));
    seg7_hex_decoder u_mag_dec (.num(mag_num), .seg(mag_glyph));

    // The outputs load from the state being left. That is why the first edge
    // after reset shows OP while the state moves on to SIGN.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_OP;
            presc       <= '0;
            bus.display <= GLYPH_BLANK;
            bus.anode   <= AN_OFF;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            case (state)
                ST_OP: begin
                    bus.display <= op_glyph;
                    bus.anode   <= AN_OP;
                    if (wrap) state <= ST_SIGN;
                end
                ST_SIGN: begin
                    bus.display <= sign_glyph;
                    bus.anode   <= AN_SIGN;
                    if (wrap) state <= ST_MAG;
                end
                ST_MAG: begin
                    bus.display <= mag_glyph;
                    bus.anode   <= AN_MAG;
                    if (wrap) state <= ST_OP;
                end
                default: begin
                    // The unused encoding recovers at once to the start of the scan.
                    state       <= ST_OP;
                    presc       <= '0;
                    bus.display <= GLYPH_BLANK;
                    bus.anode   <= AN_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_alu_display.sv
// Self-checking bench for seg7_alu_display. It runs three instances:
//   dut_a  SCAN_DIV=1, SIGNED_RESULT=1
//   dut_b  SCAN_DIV=1, SIGNED_RESULT=0
//   dut_c  SCAN_DIV=4, SIGNED_RESULT=1
// All three share clock, rst and the op/result stimulus.
module tb_seg7_alu_display;

    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam int ABS_T [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] op_drv  = 4'hF;
    logic [3:0] res_drv = 4'h9;
    int         n_checks = 0;
    int         n_err    = 0;
    int         ph       = 0;

    always #5 clock = ~clock;

    seg7_alu_display_if bus_a ();
    seg7_alu_display_if bus_b ();
    seg7_alu_display_if bus_c ();

    assign bus_a.op = op_drv;  assign bus_a.result = res_drv;
    assign bus_b.op = op_drv;  assign bus_b.result = res_drv;
    assign bus_c.op = op_drv;  assign bus_c.result = res_drv;

    seg7_alu_display #(.SCAN_DIV(1), .SIGNED_RESULT(1'b1)) dut_a (.clock(clock), .rst(rst), .bus(bus_a));
    seg7_alu_display #(.SCAN_DIV(1), .SIGNED_RESULT(1'b0)) dut_b (.clock(clock), .rst(rst), .bus(bus_b));
    seg7_alu_display #(.SCAN_DIV(4), .SIGNED_RESULT(1'b1)) dut_c (.clock(clock), .rst(rst), .bus(bus_c));

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got disp/anode=%h/%h expected %h/%h (op=%h result=%h)",
                     tag, got[14:8], got[7:0], exp[14:8], exp[7:0], op_drv, res_drv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Applies one op/result pair and checks one full scan on dut_a and dut_b.
    // ph tracks which slot the next edge loads.
    task automatic run_vec(input logic [3:0] o, input logic [3:0] r,
                           input logic [6:0] e_op, input logic [6:0] e_sign,
                           input logic [6:0] e_mag, input logic [6:0] e_bmag);
        op_drv  = o;
        res_drv = r;
        for (int k = 0; k < 3; k++) begin
            step();
            case (ph)
                0: begin
                    check("a_op", {bus_a.display, bus_a.anode}, {e_op, 8'h7F});
                    check("b_op", {bus_b.display, bus_b.anode}, {e_op, 8'h7F});
                end
                1: begin
                    check("a_sign", {bus_a.display, bus_a.anode}, {e_sign, 8'hFD});
                    check("b_sign", {bus_b.display, bus_b.anode}, {7'h7F, 8'hFD});
                end
                default: begin
                    check("a_mag", {bus_a.display, bus_a.anode}, {e_mag, 8'hFE});
                    check("b_mag", {bus_b.display, bus_b.anode}, {e_bmag, 8'hFE});
                end
            endcase
            ph = (ph == 2) ? 0 : ph + 1;
        end
    endtask

    initial begin
        // Reset held for three edges: every instance is blank with all digits off.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_a", {bus_a.display, bus_a.anode}, {7'h7F, 8'hFF});
            check("rst_b", {bus_b.display, bus_b.anode}, {7'h7F, 8'hFF});
            check("rst_c", {bus_c.display, bus_c.anode}, {7'h7F, 8'hFF});
            op_drv  = 4'(i * 5);
            res_drv = 4'(i * 3 + 8);
        end

        // Basic scan after release: op=3, result=5.
        op_drv  = 4'h3;
        res_drv = 4'h5;
        rst     = 1'b0;
        step(); check("start1", {bus_a.display, bus_a.anode}, {7'h30, 8'h7F});
        step(); check("start2", {bus_a.display, bus_a.anode}, {7'h7F, 8'hFD});
        step(); check("start3", {bus_a.display, bus_a.anode}, {7'h12, 8'hFE});
        step(); check("start4", {bus_a.display, bus_a.anode}, {7'h30, 8'h7F});
        ph = 1;

        // Directed sign/magnitude cases.
        run_vec(4'hA, 4'b1101, 7'h08, 7'h3F, 7'h30, 7'h21);
        run_vec(4'hC, 4'b1000, 7'h46, 7'h3F, 7'h00, 7'h00);
        run_vec(4'h1, 4'b0111, 7'h79, 7'h7F, 7'h78, 7'h78);

        // op sweep with result=0.
        for (int i = 0; i < 16; i++)
            run_vec(4'(i), 4'h0, GL[i], 7'h7F, 7'h40, 7'h40);

        // result sweep: dut_a shows sign and magnitude, dut_b shows raw hex.
        for (int i = 0; i < 16; i++)
            run_vec(4'(15 - i), 4'(i), GL[15 - i], (i >= 8) ? 7'h3F : 7'h7F,
                    GL[ABS_T[i]], GL[i]);

        // Prescaled scan on dut_c.
        rst = 1'b1;
        step();
        check("c_rst", {bus_c.display, bus_c.anode}, {7'h7F, 8'hFF});
        op_drv  = 4'h3;
        res_drv = 4'hE;
        rst     = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); check("c_op",   {bus_c.display, bus_c.anode}, {7'h30, 8'h7F}); end
        for (int i = 0; i < 4; i++) begin step(); check("c_sign", {bus_c.display, bus_c.anode}, {7'h3F, 8'hFD}); end
        for (int i = 0; i < 4; i++) begin step(); check("c_mag",  {bus_c.display, bus_c.anode}, {7'h24, 8'hFE}); end
        for (int i = 0; i < 4; i++) begin step(); check("c_op2",  {bus_c.display, bus_c.anode}, {7'h30, 8'h7F}); end
        step();
        check("c_sign2", {bus_c.display, bus_c.anode}, {7'h3F, 8'hFD});

        // Reset in the middle of the SIGN slot.
        rst = 1'b1;
        step();
        check("c_midrst", {bus_c.display, bus_c.anode}, {7'h7F, 8'hFF});
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); check("c_op3", {bus_c.display, bus_c.anode}, {7'h30, 8'h7F}); end
        step();
        check("c_sign3", {bus_c.display, bus_c.anode}, {7'h3F, 8'hFD});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_alu_display.md
Name: seg7_alu_display

Overview:
- Drives an 8-digit, active-low, common-anode seven-segment display for the ALU front panel.
- Shows the 4-bit opcode as a hex glyph on digit 7.
- Shows the 4-bit ALU result as a signed two's-complement value on digits 1 (sign) and 0 (magnitude).
- Time-multiplexes the three digits with a registered scan sequencer; hex-to-segment conversion is purely combinational.

Parameters:
- SCAN_DIV, default 1: clocks per scan step; each digit is held for SCAN_DIV clocks. Legal range 1..2^20.
- SIGNED_RESULT, default 1: when 1, result is shown as sign plus magnitude. When 0, digit 1 is blank and digit 0 shows raw hex of result.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  4  ALU opcode to display.
- result  in  4  ALU result to display.
- display  out  7  segment cathodes {g,f,e,d,c,b,a}; active-low (0 = lit); registered.
- anode  out  8  digit enables; active-low, one-hot-low; registered.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clock.
- Hex glyph table, index to display value:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Special glyphs: dash = 3F (segment g only); blank = 7F.
- Digit mapping, one per scan state:
  - OP: display = hex(op), anode = 0111_1111 (digit 7).
  - SIGN: anode = 1111_1101 (digit 1). With SIGNED_RESULT=1, display = dash if result[3] else blank. With SIGNED_RESULT=0, display = blank.
  - MAG: anode = 1111_1110 (digit 0). With SIGNED_RESULT=1, display = hex(|result|), where |result| = result[3] ? (~result+1) mod 16 : result, so 1000 shows 8. With SIGNED_RESULT=0, display = hex(result).
- Scan sequencer:
  - 2-bit state register with sequence OP -> SIGN -> MAG -> OP.
  - Prescaler counts 0..SCAN_DIV-1. The state advances on the clock where the prescaler wraps.
  - Unused state encoding 3 returns to OP on the next clock.
- Output timing:
  - display and anode are registered every clock from the current state and the current op/result.
  - Latency: 1 clock from an input change to the output, while the digit showing that input is selected.
- Reset:
  - While rst=1 at a clock edge: state = OP, prescaler = 0, display = 7F, anode = FF (all digits off).
  - Reset mid-scan discards the current position.
- Startup after reset release:
  - First edge with rst=0: outputs load the OP digit.
  - With SCAN_DIV=1, that edge also advances the state, so subsequent edges show SIGN, MAG, OP, ...
  - With SCAN_DIV=N: OP shown for N edges, then SIGN for N edges, then MAG for N edges.
- Exactly one anode bit is low whenever rst has been low for at least one edge.
- No X propagation: all case statements have a default that produces blank / FF.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex glyph constants;
  - GLYPH_DASH = 7'h3F and GLYPH_BLANK = 7'h7F;
  - anode patterns AN_OP = 8'h7F, AN_SIGN = 8'hFD, AN_MAG = 8'hFE;
  - the scan-state enum {ST_OP, ST_SIGN, ST_MAG}.
- Sub-module seg7_hex_decoder: combinational 4-bit number -> 7-bit cathode. It is instantiated twice, once for op and once for the magnitude/raw result.
- The top level holds the magnitude/sign logic, prescaler, sequencer and output registers.

Test Plan:
- Reset: hold rst=1 for 3 clocks with arbitrary inputs -> display=7F, anode=FF on every edge.
- Basic scan, SCAN_DIV=1, op=3, result=5, release rst:
  - edges 1..4 give (30,7F), (7F,FD), (12,FE), (30,7F).
- Negative result: op=A, result=1101 -> digit 7 shows 08, digit 1 shows 3F, digit 0 shows 30 (3).
- Boundary result: result=1000 -> digit 1 shows 3F, digit 0 shows 00 (8).
- result=0111 -> digit 1 shows 7F, digit 0 shows 78.
- Exhaustive decoder: sweep op 0..F with result=0 -> each OP slot matches the glyph table.
- Repeat with SIGNED_RESULT=0 and result 0..F -> MAG slot shows hex(result) and SIGN slot is always 7F.
- Prescale and mid-scan reset, SCAN_DIV=4 -> each anode pattern is held exactly 4 consecutive edges. Asserting rst during the SIGN slot gives FF/7F next edge; after release, the OP slot comes first.
